// File: rtl/riscv_test_monitor_if.sv
// Retire/store observation bus between the Core and the test monitor.
//   master : Core side, drives the writeback and data-store signals
//   slave  : monitor side, observes them
//   wb_valid/wb_pc : one retiring instruction and its PC
//   gp_value       : current x3 (gp)
//   st_valid/st_addr/st_data : data store issued this cycle
interface riscv_test_monitor_if #(
    parameter int unsigned XLEN = 32
);
    logic            wb_valid;
    logic [XLEN-1:0] wb_pc;
    logic [XLEN-1:0] gp_value;
    logic            st_valid;
    logic [XLEN-1:0] st_addr;
    logic [XLEN-1:0] st_data;

    modport master (
        output wb_valid, wb_pc, gp_value, st_valid, st_addr, st_data
    );

    modport slave (
        input  wb_valid, wb_pc, gp_value, st_valid, st_addr, st_data
    );
endinterface

// File: rtl/riscv_test_monitor.sv
// Pass/fail monitor for riscv-tests runs. Watches the retire and store stream
// and latches a sticky verdict from tohost store, halt PC, retire stall or timeout.
//   clk, rst          : clock, synchronous active-low reset
//   mon               : retire/store observation bus (slave)
//   done, pass        : verdict valid (sticky) and pass flag
//   cause             : 0 none, 1 tohost, 2 halt_pc, 3 stall, 4 timeout
//   fail_code         : failing test number, 0 on pass/stall/timeout
//   cycle_count       : cycles spent in RUN (saturating)
//   retire_count      : instructions retired in RUN (saturating)
module riscv_test_monitor #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] HALT_PC     = 32'h44,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h1000,
    parameter int unsigned     TIMEOUT     = 6000,
    parameter int unsigned     STALL_LIMIT = 64,
    parameter int unsigned     CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_test_monitor_if.slave   mon,
    output logic                  done,
    output logic                  pass,
    output logic [2:0]            cause,
    output logic [XLEN-1:0]       fail_code,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      retire_count
);
    localparam int unsigned     SW         = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0]   STALL_LAST = SW'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] TIME_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_TOHOST  = 3'd1;
    localparam logic [2:0] CAUSE_HALT    = 3'd2;
    localparam logic [2:0] CAUSE_STALL   = 3'd3;
    localparam logic [2:0] CAUSE_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_d;
    logic [SW-1:0]     stall_ctr, stall_ctr_d;
    logic              done_d, pass_d;
    logic [2:0]        cause_d;
    logic [XLEN-1:0]   fail_code_d;
    logic [CNT_W-1:0]  cycle_count_d, retire_count_d;

    // Raw event conditions; stall/timeout are only meaningful in RUN.
    logic e_tohost_c, e_halt_c, e_stall_c, e_timeout_c;
    assign e_tohost_c  = mon.st_valid && (mon.st_addr == TOHOST_ADDR) && (mon.st_data != '0);
    assign e_halt_c    = mon.wb_valid && (mon.wb_pc == HALT_PC);
    assign e_stall_c   = !mon.wb_valid && (stall_ctr == STALL_LAST);
    assign e_timeout_c = (cycle_count == TIME_LAST);

    // State and verdict registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            stall_ctr    <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            cause        <= CAUSE_NONE;
            fail_code    <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
        end else begin
            state        <= state_d;
            stall_ctr    <= stall_ctr_d;
            done         <= done_d;
            pass         <= pass_d;
            cause        <= cause_d;
            fail_code    <= fail_code_d;
            cycle_count  <= cycle_count_d;
            retire_count <= retire_count_d;
        end
    end

    // Next state, counters and verdict
    always_comb begin
        logic            check;
        logic            hit;
        logic            ok;
        logic [2:0]      why;
        logic [XLEN-1:0] code;

        state_d        = state;
        stall_ctr_d    = stall_ctr;
        done_d         = done;
        pass_d         = pass;
        cause_d        = cause;
        fail_code_d    = fail_code;
        cycle_count_d  = cycle_count;
        retire_count_d = retire_count;
        check          = 1'b0;
        hit            = 1'b0;
        ok             = 1'b0;
        why            = CAUSE_NONE;
        code           = '0;

        case (state)
            IDLE: begin
                if (mon.wb_valid) begin
                    state_d        = RUN;
                    cycle_count_d  = CNT_W'(1);
                    retire_count_d = CNT_W'(1);
                    stall_ctr_d    = '0;
                    check          = 1'b1;
                end
            end
            RUN: begin
                check         = 1'b1;
                cycle_count_d = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
                if (mon.wb_valid) begin
                    retire_count_d = (retire_count == '1) ? retire_count
                                                          : retire_count + CNT_W'(1);
                    stall_ctr_d    = '0;
                end else begin
                    stall_ctr_d    = stall_ctr + SW'(1);
                end
            end
            default: ;
        endcase

        // Highest-priority event wins: tohost > halt > stall > timeout
        if (check) begin
            if (e_tohost_c) begin
                hit  = 1'b1;
                ok   = (mon.st_data == XLEN'(1));
                why  = CAUSE_TOHOST;
                code = mon.st_data >> 1;
            end else if (e_halt_c) begin
                hit  = 1'b1;
                ok   = (mon.gp_value == XLEN'(1));
                why  = CAUSE_HALT;
                code = mon.gp_value >> 1;
            end else if (state == RUN && e_stall_c) begin
                hit  = 1'b1;
                why  = CAUSE_STALL;
            end else if (state == RUN && e_timeout_c) begin
                hit  = 1'b1;
                why  = CAUSE_TIMEOUT;
            end
        end

        if (hit) begin
            state_d     = DONE;
            done_d      = 1'b1;
            pass_d      = ok;
            cause_d     = why;
            fail_code_d = ok ? '0 : code;
        end
    end
endmodule
